// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// start-glitch rejection and stop-bit framing error strobe.
module uart_receiver #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rdata,
    output logic       ferr,
    output logic       busy
);

    localparam int H  = CLK_PER_BIT / 2;
    localparam int CW = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1  = CW'(H);
    localparam logic [CW-1:0] CNT_S2  = CW'(H + 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q;
    logic            rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            samp0_q, samp0_d;
    logic            samp1_q, samp1_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rx_ready_q, rx_ready_d;
    logic            ferr_q, ferr_d;

    logic            majority;
    logic            at_mid;
    logic            at_wrap;
    logic            active_d;

    // Third vote is the live synchronized sample at cnt = H+1.
    assign majority = (samp0_q & samp1_q) | (samp0_q & rxs_q) | (samp1_q & rxs_q);
    assign at_mid   = (cnt_q == CNT_S2);
    assign at_wrap  = (cnt_q == CNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_mid && majority) begin
                    state_d = IDLE;
                end else if (at_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_wrap && (bit_idx_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_mid) begin
                    state_d = majority ? IDLE : WAIT_IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // Counter only runs while a frame is in flight; IDLE always hands START a zero.
    assign active_d = (state_q != IDLE) && (state_q != WAIT_IDLE) &&
                      (state_d != IDLE) && (state_d != WAIT_IDLE);

    always_comb begin
        cnt_d      = '0;
        samp0_d    = samp0_q;
        samp1_d    = samp1_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        rx_ready_d = 1'b0;
        ferr_d     = 1'b0;

        if (active_d) begin
            cnt_d = at_wrap ? '0 : cnt_q + CW'(1);
        end

        if (cnt_q == CNT_S0) begin
            samp0_d = rxs_q;
        end
        if (cnt_q == CNT_S1) begin
            samp1_d = rxs_q;
        end

        case (state_q)
            START: begin
                bit_idx_d = 3'd0;
            end
            DATA: begin
                if (at_mid) begin
                    shift_d = {majority, shift_q[7:1]};
                end
                if (at_wrap) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (at_mid) begin
                    if (majority) begin
                        rdata_d    = shift_q;
                        rx_ready_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b0;
            rxs_q      <= 1'b0;
            cnt_q      <= '0;
            samp0_q    <= 1'b0;
            samp1_q    <= 1'b0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rdata_q    <= 8'h00;
            rx_ready_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            cnt_q      <= cnt_d;
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            rx_ready_q <= rx_ready_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign ferr     = ferr_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks/bit: frames are driven bit by bit and
// strobes are compared against an arithmetic model of frame arrival times.
module tb_uart_receiver;

    localparam int     CPB = 16;
    localparam int     H   = CPB / 2;
    // rxd fall to strobe: 2 sync cycles, then t + 9*CPB + H + 3
    localparam longint LAT = 2 + 9 * CPB + H + 3;

    typedef struct {
        longint     c;
        logic [7:0] d;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic       rx_ready;
    logic       ferr;
    logic       busy;
    logic [7:0] rdata;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     both_cnt = 0;

    ev_t    rdy_q[$];
    longint ferr_q[$];
    ev_t    exp_q[$];
    longint exp_ferr_q[$];
    logic [7:0] model_rdata;

    uart_receiver #(.CLK_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rdata    (rdata),
        .ferr     (ferr),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_ready) begin
                ev_t ev;
                ev.c = cyc;
                ev.d = rdata;
                rdy_q.push_back(ev);
            end
            if (ferr) ferr_q.push_back(cyc);
            if (rx_ready && ferr) both_cnt++;
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Even bit slots last pa cycles, odd slots pb cycles.
    task automatic send_frame(input logic [7:0] d, input int pa, input int pb,
                              input logic stop, output longint fall);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat ((i % 2 == 0) ? pa : pb) @(posedge clock);
            #1;
        end
        rxd = 1'b1;
    endtask

    // Reference: a nominal-rate frame yields its strobe LAT cycles after the fall.
    task automatic model_frame(input longint fall, input logic [7:0] d, input logic stop);
        ev_t ev;
        if (stop) begin
            ev.c = fall + LAT;
            ev.d = d;
            exp_q.push_back(ev);
            model_rdata = d;
        end else begin
            exp_ferr_q.push_back(fall + LAT);
        end
    endtask

    task automatic clear_all();
        rdy_q.delete();
        ferr_q.delete();
        exp_q.delete();
        exp_ferr_q.delete();
    endtask

    task automatic test_reset();
        longint fall;
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        reset = 1'b0;
        idle(5);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
        clear_all();
        send_frame(8'h99, CPB, CPB, 1'b1, fall);
        model_frame(fall, 8'h99, 1'b1);
        idle(8);
        n_vec++;
        if (rdy_q.size() != 1) begin
            n_err++; $display("FAIL first_count: got %0d want 1", rdy_q.size());
        end else if (rdy_q[0].d !== exp_q[0].d || rdy_q[0].c != exp_q[0].c) begin
            n_err++; $display("FAIL first_byte: got %h@%0d want %h@%0d", rdy_q[0].d, rdy_q[0].c, exp_q[0].d, exp_q[0].c);
        end
        n_vec++; if (ferr_q.size() != 0) begin n_err++; $display("FAIL first_ferr: got %0d pulses want 0", ferr_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        longint fall;
        bytes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
        clear_all();
        for (int i = 0; i < 6; i++) begin
            send_frame(bytes[i], CPB, CPB, 1'b1, fall);
            model_frame(fall, bytes[i], 1'b1);
        end
        idle(8);
        n_vec++; if (rdy_q.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", rdy_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= rdy_q.size()) begin
                n_err++; $display("FAIL b2b_byte%0d: got none want %h", i, exp_q[i].d);
            end else if (rdy_q[i].d !== exp_q[i].d || rdy_q[i].c != exp_q[i].c) begin
                n_err++; $display("FAIL b2b_byte%0d: got %h@%0d want %h@%0d", i, rdy_q[i].d, rdy_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        if (rdy_q.size() == 6) begin
            for (int i = 1; i < 6; i++) begin
                n_vec++;
                if (rdy_q[i].c - rdy_q[i-1].c != 10 * CPB) begin
                    n_err++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, rdy_q[i].c - rdy_q[i-1].c, 10 * CPB);
                end
            end
        end
        n_vec++; if (ferr_q.size() != 0) begin n_err++; $display("FAIL b2b_ferr: got %0d want 0", ferr_q.size()); end
    endtask

    task automatic test_glitch();
        longint fall;
        clear_all();
        rxd = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        idle(30);
        n_vec++; if (rdy_q.size() != 0 || ferr_q.size() != 0) begin n_err++; $display("FAIL glitch_strobe: got %0d/%0d want 0/0", rdy_q.size(), ferr_q.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
        n_vec++; if (rdata !== model_rdata) begin n_err++; $display("FAIL glitch_rdata: got %h want %h", rdata, model_rdata); end
        send_frame(8'h3C, CPB, CPB, 1'b1, fall);
        model_frame(fall, 8'h3C, 1'b1);
        idle(8);
        n_vec++;
        if (rdy_q.size() != 1) begin
            n_err++; $display("FAIL glitch_next_count: got %0d want 1", rdy_q.size());
        end else if (rdy_q[0].d !== exp_q[0].d || rdy_q[0].c != exp_q[0].c) begin
            n_err++; $display("FAIL glitch_next_byte: got %h@%0d want %h@%0d", rdy_q[0].d, rdy_q[0].c, exp_q[0].d, exp_q[0].c);
        end
    endtask

    task automatic test_framing_error();
        longint fall;
        clear_all();
        send_frame(8'hF0, CPB, CPB, 1'b0, fall);
        model_frame(fall, 8'hF0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        n_vec++;
        if (ferr_q.size() != 1) begin
            n_err++; $display("FAIL ferr_count: got %0d want 1", ferr_q.size());
        end else if (ferr_q[0] != exp_ferr_q[0]) begin
            n_err++; $display("FAIL ferr_cycle: got %0d want %0d", ferr_q[0], exp_ferr_q[0]);
        end
        n_vec++; if (rdy_q.size() != 0) begin n_err++; $display("FAIL ferr_ready: got %0d want 0", rdy_q.size()); end
        n_vec++; if (rdata !== model_rdata) begin n_err++; $display("FAIL ferr_rdata: got %h want %h", rdata, model_rdata); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy: got %b want 1", busy); end
        idle(2 * CPB);
        clear_all();
        send_frame(8'h12, CPB, CPB, 1'b1, fall);
        model_frame(fall, 8'h12, 1'b1);
        idle(8);
        n_vec++;
        if (rdy_q.size() != 1) begin
            n_err++; $display("FAIL after_break_count: got %0d want 1", rdy_q.size());
        end else if (rdy_q[0].d !== exp_q[0].d || rdy_q[0].c != exp_q[0].c) begin
            n_err++; $display("FAIL after_break_byte: got %h@%0d want %h@%0d", rdy_q[0].d, rdy_q[0].c, exp_q[0].d, exp_q[0].c);
        end
    endtask

    task automatic test_reset_mid_frame();
        longint fall;
        clear_all();
        fork
            begin
                longint f0;
                send_frame(8'hA5, CPB, CPB, 1'b1, f0);
            end
            begin
                repeat (5 * CPB + H) @(posedge clock);
                #1;
                reset = 1'b1;
                repeat (5 * CPB + H) @(posedge clock);
                #1;
                reset = 1'b0;
            end
        join
        model_rdata = 8'h00;
        n_vec++; if (rdy_q.size() != 0 || ferr_q.size() != 0) begin n_err++; $display("FAIL midreset_strobe: got %0d/%0d want 0/0", rdy_q.size(), ferr_q.size()); end
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL midreset_rdata: got %h want 00", rdata); end
        idle(CPB);
        send_frame(8'h5A, CPB, CPB, 1'b1, fall);
        model_frame(fall, 8'h5A, 1'b1);
        idle(8);
        n_vec++;
        if (rdy_q.size() != 1) begin
            n_err++; $display("FAIL midreset_next_count: got %0d want 1", rdy_q.size());
        end else if (rdy_q[0].d !== exp_q[0].d || rdy_q[0].c != exp_q[0].c) begin
            n_err++; $display("FAIL midreset_next_byte: got %h@%0d want %h@%0d", rdy_q[0].d, rdy_q[0].c, exp_q[0].d, exp_q[0].c);
        end
    endtask

    task automatic test_baud_tolerance();
        longint     fall;
        logic [7:0] b;
        int         pa [3];
        int         pb [3];
        logic [7:0] bv [3];
        b  = 8'($urandom_range(0, 255));
        pa = '{17, 16, 17};
        pb = '{17, 15, 17};
        bv = '{8'hC3, 8'hC3, b};
        for (int i = 0; i < 3; i++) begin
            clear_all();
            send_frame(bv[i], pa[i], pb[i], 1'b1, fall);
            idle(2 * CPB);
            n_vec++;
            if (rdy_q.size() != 1) begin
                n_err++; $display("FAIL baud%0d_count: got %0d want 1", i, rdy_q.size());
            end else if (rdy_q[0].d !== bv[i]) begin
                n_err++; $display("FAIL baud%0d_byte: got %h want %h", i, rdy_q[0].d, bv[i]);
            end
            n_vec++; if (ferr_q.size() != 0) begin n_err++; $display("FAIL baud%0d_ferr: got %0d want 0", i, ferr_q.size()); end
        end
        model_rdata = b;
    endtask

    task automatic test_random();
        longint     fall;
        logic [7:0] d;
        logic       stop;
        int         gap;
        clear_all();
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? $urandom_range(0, 20) : $urandom_range(2, 20);
            send_frame(d, CPB, CPB, stop, fall);
            model_frame(fall, d, stop);
            if (gap > 0) idle(gap);
        end
        idle(8);
        n_vec++; if (rdy_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", rdy_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= rdy_q.size()) begin
                n_err++; $display("FAIL rand_byte%0d: got none want %h", i, exp_q[i].d);
            end else if (rdy_q[i].d !== exp_q[i].d || rdy_q[i].c != exp_q[i].c) begin
                n_err++; $display("FAIL rand_byte%0d: got %h@%0d want %h@%0d", i, rdy_q[i].d, rdy_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        n_vec++; if (ferr_q != exp_ferr_q) begin n_err++; $display("FAIL rand_ferr: got %0d pulses want %0d", ferr_q.size(), exp_ferr_q.size()); end
        n_vec++; if (rdata !== model_rdata) begin n_err++; $display("FAIL rand_rdata: got %h want %h", rdata, model_rdata); end
        n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        model_rdata = 8'h00;
        @(posedge clock);
        #1;
        test_reset();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
